pc_redirect_ctrl: RTL and testbench

//   Sequences the PC register. Arbitrates redirect requests from EX (branch/jump)
//   and the trap unit, and combines stall sources into one hold. Produces a single
//   jmp_en/jmp_addr/hold triple for the PC register plus a front-end flush strobe.
//   A redirect that arrives while the fetch bus is stalled is parked and replayed later.

---
 rtl/pc_redirect_ctrl.sv | 138 +++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_ctrl.sv
// PC redirect sequencer: arbitrates trap and EX redirects, merges stall sources
// into hold, parks redirects blocked by a stalled fetch bus, and times the front-end flush.
module pc_redirect_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_jmp_req_i,
  input  logic [ADDR_W-1:0] ex_jmp_addr_i,
  input  logic              trap_req_i,
  input  logic [ADDR_W-1:0] trap_addr_i,
  input  logic              bus_stall_i,
  input  logic              div_busy_i,
  output logic              jmp_en_o,
  output logic [ADDR_W-1:0] jmp_addr_o,
  output logic              hold_o,
  output logic              flush_o,
  output logic              trap_ack_o,
  output logic [1:0]        state_o
);

  // state | meaning
  // IDLE  | no redirect in flight; requests issue in the same cycle when the bus is free
  // PEND  | redirect parked in pend_addr until the fetch bus accepts it
  // FLUSH | front end being squashed for flush_cnt unstalled cycles
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PEND  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]        state, state_nxt;
  logic [ADDR_W-1:0] pend_addr, pend_addr_nxt;
  logic              pend_is_trap, pend_is_trap_nxt;
  logic [CNT_W-1:0]  flush_cnt, flush_cnt_nxt;

  logic              issue;
  logic              issue_trap;
  logic [ADDR_W-1:0] issue_addr;
  logic              flush;
  logic [ADDR_W-1:0] win_addr;

  assign win_addr = trap_req_i ? trap_addr_i : ex_jmp_addr_i;

  always_comb begin
    state_nxt        = state;
    pend_addr_nxt    = pend_addr;
    pend_is_trap_nxt = pend_is_trap;
    flush_cnt_nxt    = flush_cnt;
    issue            = 1'b0;
    issue_trap       = 1'b0;
    issue_addr       = '0;
    flush            = 1'b0;
    case (state)
      S_IDLE: begin
        if (trap_req_i || ex_jmp_req_i) begin
          if (!bus_stall_i) begin
            issue         = 1'b1;
            issue_trap    = trap_req_i;
            issue_addr    = win_addr;
            flush_cnt_nxt = CNT_LOAD;
            state_nxt     = S_FLUSH;
          end else begin
            pend_addr_nxt    = win_addr;
            pend_is_trap_nxt = trap_req_i;
            state_nxt        = S_PEND;
          end
        end
      end
      S_PEND: begin
        // EX is frozen while parked, so only a trap may replace the pending target
        if (bus_stall_i) begin
          if (trap_req_i && !pend_is_trap) begin
            pend_addr_nxt    = trap_addr_i;
            pend_is_trap_nxt = 1'b1;
          end
        end else begin
          issue            = 1'b1;
          issue_trap       = pend_is_trap;
          issue_addr       = pend_addr;
          pend_is_trap_nxt = 1'b0;
          flush_cnt_nxt    = CNT_LOAD;
          state_nxt        = S_FLUSH;
        end
      end
      S_FLUSH: begin
        flush = 1'b1;
        if (trap_req_i) begin
          if (!bus_stall_i) begin
            issue         = 1'b1;
            issue_trap    = 1'b1;
            issue_addr    = trap_addr_i;
            flush_cnt_nxt = CNT_LOAD;
          end else begin
            pend_addr_nxt    = trap_addr_i;
            pend_is_trap_nxt = 1'b1;
            state_nxt        = S_PEND;
          end
        end else if (!bus_stall_i) begin
          if (flush_cnt == CNT_ONE) begin
            flush_cnt_nxt = '0;
            state_nxt     = S_IDLE;
          end else begin
            flush_cnt_nxt = flush_cnt - CNT_ONE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (issue) flush = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      pend_addr    <= '0;
      pend_is_trap <= 1'b0;
      flush_cnt    <= '0;
    end else begin
      state        <= state_nxt;
      pend_addr    <= pend_addr_nxt;
      pend_is_trap <= pend_is_trap_nxt;
      flush_cnt    <= flush_cnt_nxt;
    end
  end

  // Issue is combinational from IDLE, so outputs are gated to stay quiet during reset
  assign jmp_en_o   = issue & rst_n;
  assign jmp_addr_o = (issue && rst_n) ? issue_addr : '0;
  assign flush_o    = flush & rst_n;
  assign trap_ack_o = issue & issue_trap & rst_n;
  assign hold_o     = bus_stall_i | div_busy_i | (state == S_PEND);
  assign state_o    = state;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl: hand-computed expectations checked mid-cycle
// with immediate assertions.
module tb_pc_redirect_ctrl;

  logic        clk;
  logic        rst_n;
  logic        ex_jmp_req;
  logic [31:0] ex_jmp_addr;
  logic        trap_req;
  logic [31:0] trap_addr;
  logic        bus_stall;
  logic        div_busy;
  logic        jmp_en;
  logic [31:0] jmp_addr;
  logic        hold;
  logic        flush;
  logic        trap_ack;
  logic [1:0]  state;

  int n_assert = 0;
  int n_fail   = 0;

  pc_redirect_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_jmp_req_i (ex_jmp_req),
    .ex_jmp_addr_i(ex_jmp_addr),
    .trap_req_i   (trap_req),
    .trap_addr_i  (trap_addr),
    .bus_stall_i  (bus_stall),
    .div_busy_i   (div_busy),
    .jmp_en_o     (jmp_en),
    .jmp_addr_o   (jmp_addr),
    .hold_o       (hold),
    .flush_o      (flush),
    .trap_ack_o   (trap_ack),
    .state_o      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic en, input logic [31:0] addr,
                         input logic fl, input logic ack, input logic hd, input logic [1:0] st);
    chk({tag, ".jmp_en"},   {31'd0, jmp_en},   {31'd0, en});
    chk({tag, ".jmp_addr"}, jmp_addr,          addr);
    chk({tag, ".flush"},    {31'd0, flush},    {31'd0, fl});
    chk({tag, ".trap_ack"}, {31'd0, trap_ack}, {31'd0, ack});
    chk({tag, ".hold"},     {31'd0, hold},     {31'd0, hd});
    chk({tag, ".state"},    {30'd0, state},    {30'd0, st});
  endtask

  // Advance to just after the next rising edge; checks happen 3 ns later.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ex_jmp_req = 1'b1; ex_jmp_addr = 32'h100;
    trap_req = 1'b0; trap_addr = 32'h0; bus_stall = 1'b1; div_busy = 1'b0;
    #2;
    chk_all("reset", 0, 32'h0, 0, 0, 1, 0);
    #8;
    rst_n = 1'b1; ex_jmp_req = 1'b0; bus_stall = 1'b0;

    // 1: zero-latency EX redirect, three flush cycles
    next(); ex_jmp_req = 1; ex_jmp_addr = 32'h100; #3;
    chk_all("t1.issue", 1, 32'h100, 1, 0, 0, 0);
    next(); ex_jmp_req = 0; #3;
    chk_all("t1.fl1", 0, 32'h0, 1, 0, 0, 2);
    next(); #3;
    chk_all("t1.fl2", 0, 32'h0, 1, 0, 0, 2);
    next(); #3;
    chk_all("t1.idle", 0, 32'h0, 0, 0, 0, 0);

    // 2: trap beats EX; EX held into FLUSH is ignored
    next(); trap_req = 1; trap_addr = 32'h80; ex_jmp_req = 1; ex_jmp_addr = 32'h100; #3;
    chk_all("t2.issue", 1, 32'h80, 1, 1, 0, 0);
    next(); trap_req = 0; #3;
    chk_all("t2.fl1", 0, 32'h0, 1, 0, 0, 2);
    next(); ex_jmp_req = 0; #3;
    chk_all("t2.fl2", 0, 32'h0, 1, 0, 0, 2);
    next(); #3;
    chk_all("t2.idle", 0, 32'h0, 0, 0, 0, 0);

    // 3: EX redirect parked behind a 4-cycle bus stall
    next(); ex_jmp_req = 1; ex_jmp_addr = 32'h200; bus_stall = 1; #3;
    chk_all("t3.park", 0, 32'h0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      next(); ex_jmp_addr = 32'h300; #3;
      chk_all("t3.pend", 0, 32'h0, 0, 0, 1, 1);
    end
    next(); bus_stall = 0; #3;
    chk_all("t3.release", 1, 32'h200, 1, 0, 1, 1);
    next(); ex_jmp_req = 0; #3;
    chk_all("t3.fl1", 0, 32'h0, 1, 0, 0, 2);
    next(); next(); #3;
    chk_all("t3.idle", 0, 32'h0, 0, 0, 0, 0);

    // 4: trap overrides a parked EX target
    next(); ex_jmp_req = 1; ex_jmp_addr = 32'h200; bus_stall = 1; #3;
    chk_all("t4.park", 0, 32'h0, 0, 0, 1, 0);
    next(); ex_jmp_req = 0; trap_req = 1; trap_addr = 32'h80; #3;
    chk_all("t4.trap_in", 0, 32'h0, 0, 0, 1, 1);
    next(); bus_stall = 0; #3;
    chk_all("t4.release", 1, 32'h80, 1, 1, 1, 1);
    next(); trap_req = 0; #3;
    chk_all("t4.fl1", 0, 32'h0, 1, 0, 0, 2);
    next(); next(); #3;
    chk_all("t4.idle", 0, 32'h0, 0, 0, 0, 0);

    // 5: FLUSH ignores EX, restarts on trap, freezes under stall
    next(); ex_jmp_req = 1; ex_jmp_addr = 32'h100; #3;
    chk_all("t5.issue", 1, 32'h100, 1, 0, 0, 0);
    next(); ex_jmp_addr = 32'h300; #3;
    chk_all("t5.ex_ign", 0, 32'h0, 1, 0, 0, 2);
    next(); ex_jmp_req = 0; trap_req = 1; trap_addr = 32'h80; #3;
    chk_all("t5.trap", 1, 32'h80, 1, 1, 0, 2);
    next(); trap_req = 0; bus_stall = 1; #3;
    chk_all("t5.stall1", 0, 32'h0, 1, 0, 1, 2);
    next(); #3;
    chk_all("t5.stall2", 0, 32'h0, 1, 0, 1, 2);
    next(); bus_stall = 0; #3;
    chk_all("t5.run1", 0, 32'h0, 1, 0, 0, 2);
    next(); #3;
    chk_all("t5.run2", 0, 32'h0, 1, 0, 0, 2);
    next(); #3;
    chk_all("t5.idle", 0, 32'h0, 0, 0, 0, 0);

    // 5b: trap during FLUSH under stall parks, then issues on release
    next(); ex_jmp_req = 1; ex_jmp_addr = 32'h140; #3;
    chk_all("t5b.issue", 1, 32'h140, 1, 0, 0, 0);
    next(); ex_jmp_req = 0; trap_req = 1; trap_addr = 32'h90; bus_stall = 1; #3;
    chk_all("t5b.park", 0, 32'h0, 1, 0, 1, 2);
    next(); #3;
    chk_all("t5b.pend", 0, 32'h0, 0, 0, 1, 1);
    next(); bus_stall = 0; #3;
    chk_all("t5b.release", 1, 32'h90, 1, 1, 1, 1);
    next(); trap_req = 0; next(); next(); #3;
    chk_all("t5b.idle", 0, 32'h0, 0, 0, 0, 0);

    // 6: async reset while parked discards the redirect
    next(); ex_jmp_req = 1; ex_jmp_addr = 32'h200; bus_stall = 1; #3;
    chk_all("t6.park", 0, 32'h0, 0, 0, 1, 0);
    next(); ex_jmp_req = 0; #2;
    chk_all("t6.pend", 0, 32'h0, 0, 0, 1, 1);
    rst_n = 0; #1;
    chk_all("t6.rst", 0, 32'h0, 0, 0, 1, 0);
    #2; bus_stall = 0; rst_n = 1; #1;
    chk_all("t6.post", 0, 32'h0, 0, 0, 0, 0);
    next(); #3;
    chk_all("t6.no_issue", 0, 32'h0, 0, 0, 0, 0);

    // div_busy raises hold but does not gate a redirect
    next(); div_busy = 1; #3;
    chk_all("t7.busy", 0, 32'h0, 0, 0, 1, 0);
    ex_jmp_req = 1; ex_jmp_addr = 32'h400; #1;
    chk_all("t7.issue", 1, 32'h400, 1, 0, 1, 0);
    next(); ex_jmp_req = 0; div_busy = 0; next(); next(); #3;
    chk_all("t7.idle", 0, 32'h0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
